// File: rtl/register_ac_alu_pkg.sv
// Shared definitions for the register_ac_alu accumulator unit.
//   - Opcode encodings (OP_NOP .. OP_ROL_N); 13-15 are unused and act as NOP.
//   - FSM state encoding for the iterative rotate sequencer.
//   - Rotate direction constants (independent of the data width).
package register_ac_alu_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_CLA   = 4'd1;
    localparam logic [3:0] OP_CLE   = 4'd2;
    localparam logic [3:0] OP_CMA   = 4'd3;
    localparam logic [3:0] OP_CME   = 4'd4;
    localparam logic [3:0] OP_CIR   = 4'd5;
    localparam logic [3:0] OP_CIL   = 4'd6;
    localparam logic [3:0] OP_INC   = 4'd7;
    localparam logic [3:0] OP_ADD   = 4'd8;
    localparam logic [3:0] OP_AND   = 4'd9;
    localparam logic [3:0] OP_LDA   = 4'd10;
    localparam logic [3:0] OP_ROR_N = 4'd11;
    localparam logic [3:0] OP_ROL_N = 4'd12;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/register_ac_alu_ac_alu_comb.sv
// Single-step combinational ALU for the accumulator/E pair.
// Ports:
//   op      : opcode (single-step ops only; anything else passes AC/E through)
//   ac, e   : current accumulator and E flag
//   data    : bus operand for ADD/AND/LDA
//   ac_next : accumulator after one step
//   e_next  : E flag after one step
module ac_alu_comb
    import register_ac_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] ac,
    input  logic             e,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] ac_next,
    output logic             e_next
);

    // Carry-out of the add lands in E, so the sum is one bit wider than AC.
    logic [WIDTH:0] sum;
    assign sum = {1'b0, ac} + {1'b0, data};

    always_comb begin
        ac_next = ac;
        e_next  = e;
        case (op)
            OP_CLA: ac_next = '0;
            OP_CLE: e_next  = 1'b0;
            OP_CMA: ac_next = ~ac;
            OP_CME: e_next  = ~e;
            // Rotates treat {AC,E} as one WIDTH+1 bit ring.
            OP_CIR: begin
                ac_next = {e, ac[WIDTH-1:1]};
                e_next  = ac[0];
            end
            OP_CIL: begin
                ac_next = {ac[WIDTH-2:0], e};
                e_next  = ac[WIDTH-1];
            end
            OP_INC: ac_next = ac + WIDTH'(1);
            OP_ADD: {e_next, ac_next} = sum;
            OP_AND: ac_next = ac & data;
            OP_LDA: ac_next = data;
            default: begin
                ac_next = ac;
                e_next  = e;
            end
        endcase
    end

endmodule

// File: rtl/register_ac_alu.sv
// Accumulator (AC) plus E flag with opcode-driven register-reference/ALU ops.
// Single-step ops complete at the acceptance edge; ROR_N/ROL_N rotate one bit
// per cycle behind a valid/ready handshake.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   op_valid, op_ready   : opcode handshake (ready only while idle)
//   op_code, shamt       : operation and rotate count, sampled at acceptance
//   DATA_in              : bus operand for ADD/AND/LDA
//   op_done              : one-cycle pulse after an operation completes
//   op_of_ac, e_flag     : accumulator and E register
//   zero_flag, neg_flag  : combinational status derived from AC
module register_ac_alu
    import register_ac_alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    input  logic [3:0]         op_code,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   DATA_in,
    output logic               op_ready,
    output logic               op_done,
    output logic [WIDTH-1:0]   op_of_ac,
    output logic               e_flag,
    output logic               zero_flag,
    output logic               neg_flag
);

    state_t             state_reg, state_next;
    logic [SHAMT_W-1:0] count_reg, count_next;
    logic               dir_reg, dir_next;
    logic [WIDTH-1:0]   ac_reg, ac_next;
    logic               e_reg, e_next;
    logic               done_reg, done_next;

    logic [3:0]         alu_op;
    logic [WIDTH-1:0]   alu_ac;
    logic               alu_e;
    logic               is_rot_op;

    assign is_rot_op = (op_code == OP_ROR_N) || (op_code == OP_ROL_N);

    // Multi-bit rotates are mapped onto the single-bit CIR/CIL step, both at
    // acceptance and for every later SHIFT cycle.
    always_comb begin
        alu_op = OP_NOP;
        if (state_reg == ST_SHIFT) begin
            alu_op = (dir_reg == DIR_LEFT) ? OP_CIL : OP_CIR;
        end else if (is_rot_op) begin
            alu_op = (op_code == OP_ROL_N) ? OP_CIL : OP_CIR;
        end else begin
            alu_op = op_code;
        end
    end

    ac_alu_comb #(.WIDTH(WIDTH)) u_alu (
        .op      (alu_op),
        .ac      (ac_reg),
        .e       (e_reg),
        .data    (DATA_in),
        .ac_next (alu_ac),
        .e_next  (alu_e)
    );

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        dir_next   = dir_reg;
        ac_next    = ac_reg;
        e_next     = e_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (op_valid) begin
                    done_next = 1'b1;
                    if (is_rot_op) begin
                        // A zero count is a plain NOP that still reports done.
                        if (shamt != '0) begin
                            ac_next    = alu_ac;
                            e_next     = alu_e;
                            count_next = shamt - SHAMT_W'(1);
                            dir_next   = (op_code == OP_ROL_N) ? DIR_LEFT : DIR_RIGHT;
                            if (shamt != SHAMT_W'(1)) begin
                                state_next = ST_SHIFT;
                                done_next  = 1'b0;
                            end
                        end
                    end else begin
                        ac_next = alu_ac;
                        e_next  = alu_e;
                    end
                end
            end
            ST_SHIFT: begin
                ac_next    = alu_ac;
                e_next     = alu_e;
                count_next = count_reg - SHAMT_W'(1);
                if (count_reg == SHAMT_W'(1)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            dir_reg   <= DIR_RIGHT;
            ac_reg    <= '0;
            e_reg     <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            dir_reg   <= dir_next;
            ac_reg    <= ac_next;
            e_reg     <= e_next;
            done_reg  <= done_next;
        end
    end

    assign op_ready  = (state_reg == ST_IDLE);
    assign op_done   = done_reg;
    assign op_of_ac  = ac_reg;
    assign e_flag    = e_reg;
    assign zero_flag = (ac_reg == '0);
    assign neg_flag  = ac_reg[WIDTH-1];

endmodule
